// File: rtl/lcd_timing_pkg.sv
// Shared definitions for the LCD timing generator: FSM states, default
// 720x1280 panel timing and the line/frame total helpers.
package lcd_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  localparam int DEF_H_SYNC = 4;
  localparam int DEF_H_BP   = 20;
  localparam int DEF_H_DISP = 720;
  localparam int DEF_H_FP   = 20;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 10;
  localparam int DEF_V_DISP = 1280;
  localparam int DEF_V_FP   = 10;

  function automatic int h_total(input int sync_w, input int bp, input int disp, input int fp);
    return sync_w + bp + disp + fp;
  endfunction

  function automatic int v_total(input int sync_w, input int bp, input int disp, input int fp);
    return sync_w + bp + disp + fp;
  endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Horizontal/vertical position counters with wrap logic and the
// last-cycle-of-frame flag used by the scheduler.
module video_timing_counter
  import lcd_timing_pkg::*;
#(
  parameter int H_TOTAL = h_total(DEF_H_SYNC, DEF_H_BP, DEF_H_DISP, DEF_H_FP),
  parameter int V_TOTAL = v_total(DEF_V_SYNC, DEF_V_BP, DEF_V_DISP, DEF_V_FP)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_i,
  output logic [11:0] h_cnt_o,
  output logic [11:0] v_cnt_o,
  output logic        boundary_o
);

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;
  logic        h_wrap_s, v_wrap_s;

  // Next position; counters sit at the origin whenever the generator is idle
  always_comb begin
    h_cnt_d  = h_cnt_q;
    v_cnt_d  = v_cnt_q;
    h_wrap_s = (h_cnt_q == H_LAST);
    v_wrap_s = (v_cnt_q == V_LAST);
    if (!run_i) begin
      h_cnt_d = 12'd0;
      v_cnt_d = 12'd0;
    end else if (h_wrap_s) begin
      h_cnt_d = 12'd0;
      if (v_wrap_s) begin
        v_cnt_d = 12'd0;
      end else begin
        v_cnt_d = v_cnt_q + 12'd1;
      end
    end else begin
      h_cnt_d = h_cnt_q + 12'd1;
    end
  end

  // Position registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= 12'd0;
      v_cnt_q <= 12'd0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt_o    = h_cnt_q;
  assign v_cnt_o    = v_cnt_q;
  assign boundary_o = run_i && h_wrap_s && v_wrap_s;

endmodule

// File: rtl/lcd_pattern_scheduler.sv
// Video timing front end: run/stop FSM, frame-boundary pattern scheduling
// and the two-stage output pipeline that lines up with the pattern generator.
module lcd_pattern_scheduler
  import lcd_timing_pkg::*;
#(
  parameter int H_SYNC         = DEF_H_SYNC,
  parameter int H_BP           = DEF_H_BP,
  parameter int H_DISP         = DEF_H_DISP,
  parameter int H_FP           = DEF_H_FP,
  parameter int V_SYNC         = DEF_V_SYNC,
  parameter int V_BP           = DEF_V_BP,
  parameter int V_DISP         = DEF_V_DISP,
  parameter int V_FP           = DEF_V_FP,
  parameter int FRAMES_PER_PAT = 60,
  parameter int NUM_PAT        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        next_req,
  output logic        data_req,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic [10:0] h_disp,
  output logic [10:0] v_disp,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic [1:0]  pat_sel,
  output logic        busy
);

  localparam int          H_TOTAL   = h_total(H_SYNC, H_BP, H_DISP, H_FP);
  localparam int          V_TOTAL   = v_total(V_SYNC, V_BP, V_DISP, V_FP);
  localparam logic [11:0] H_ACT_BEG = 12'(H_SYNC + H_BP);
  localparam logic [11:0] H_ACT_END = 12'(H_SYNC + H_BP + H_DISP - 1);
  localparam logic [11:0] V_ACT_BEG = 12'(V_SYNC + V_BP);
  localparam logic [11:0] V_ACT_END = 12'(V_SYNC + V_BP + V_DISP - 1);
  localparam logic [11:0] H_SYNC_END = 12'(H_SYNC);
  localparam logic [11:0] V_SYNC_END = 12'(V_SYNC);
  localparam logic [15:0] FC_LAST   = 16'(FRAMES_PER_PAT - 1);
  localparam logic [1:0]  PAT_LAST  = 2'(NUM_PAT - 1);

  state_e      state_q, state_d;
  logic        busy_s, boundary_s, adv_s;
  logic [11:0] h_cnt_s, v_cnt_s;
  logic        h_act_s, v_act_s;

  logic [1:0]  pat_sel_q, pat_sel_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        pend_q, pend_d;

  logic        dr_q, dr_d;
  logic [10:0] xpos_q, xpos_d, ypos_q, ypos_d;
  logic        fs_q, fs_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic        de_q, hs2_q, vs2_q;

  assign busy_s = (state_q != ST_IDLE);

  video_timing_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_i      (busy_s),
    .h_cnt_o    (h_cnt_s),
    .v_cnt_o    (v_cnt_s),
    .boundary_o (boundary_s)
  );

  // Run/stop control; STOP lets the current frame finish before idling
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable) state_d = ST_RUN;  else state_d = ST_IDLE;
      ST_RUN:  if (!enable) state_d = ST_STOP; else state_d = ST_RUN;
      ST_STOP: begin
        if (enable) begin
          state_d = ST_RUN;
        end else if (boundary_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pattern selection only changes at a frame boundary; requests coalesce
  always_comb begin
    pat_sel_d   = pat_sel_q;
    frame_cnt_d = frame_cnt_q;
    pend_d      = pend_q;
    adv_s       = (frame_cnt_q == FC_LAST) || pend_q || next_req;
    if (boundary_s) begin
      if (adv_s) begin
        pat_sel_d   = (pat_sel_q == PAT_LAST) ? 2'd0 : (pat_sel_q + 2'd1);
        frame_cnt_d = 16'd0;
        pend_d      = 1'b0;
      end else begin
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
    end else if (busy_s && next_req) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end
  end

  // Stage-1 decode of the current counter position
  always_comb begin
    h_act_s = (h_cnt_s >= H_ACT_BEG) && (h_cnt_s <= H_ACT_END);
    v_act_s = (v_cnt_s >= V_ACT_BEG) && (v_cnt_s <= V_ACT_END);
    dr_d    = busy_s && h_act_s && v_act_s;
    xpos_d  = dr_d ? 11'(h_cnt_s - H_ACT_BEG) : 11'd0;
    ypos_d  = dr_d ? 11'(v_cnt_s - V_ACT_BEG) : 11'd0;
    fs_d    = busy_s && (h_cnt_s == 12'd0) && (v_cnt_s == 12'd0);
    hs1_d   = busy_s && (h_cnt_s < H_SYNC_END);
    vs1_d   = busy_s && (v_cnt_s < V_SYNC_END);
  end

  // Control and scheduling state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pat_sel_q   <= 2'd0;
      frame_cnt_q <= 16'd0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_sel_q   <= pat_sel_d;
      frame_cnt_q <= frame_cnt_d;
      pend_q      <= pend_d;
    end
  end

  // Output pipeline: stage 1 feeds the generator, stage 2 matches its latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dr_q   <= 1'b0;
      xpos_q <= 11'd0;
      ypos_q <= 11'd0;
      fs_q   <= 1'b0;
      hs1_q  <= 1'b0;
      vs1_q  <= 1'b0;
      de_q   <= 1'b0;
      hs2_q  <= 1'b0;
      vs2_q  <= 1'b0;
    end else begin
      dr_q   <= dr_d;
      xpos_q <= xpos_d;
      ypos_q <= ypos_d;
      fs_q   <= fs_d;
      hs1_q  <= hs1_d;
      vs1_q  <= vs1_d;
      de_q   <= dr_q;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
    end
  end

  assign data_req    = dr_q;
  assign pixel_xpos  = xpos_q;
  assign pixel_ypos  = ypos_q;
  assign frame_start = fs_q;
  assign de          = de_q;
  assign hsync       = hs2_q;
  assign vsync       = vs2_q;
  assign pat_sel     = pat_sel_q;
  assign busy        = busy_s;
  assign h_disp      = 11'(H_DISP);
  assign v_disp      = 11'(V_DISP);

endmodule

// File: tb/tb_lcd_pattern_scheduler.sv
// Directed scenarios plus randomized enable/next_req traffic, checked every
// cycle against a frame-position reference model.
module tb_lcd_pattern_scheduler;

  localparam int HS = 4, HB = 2, HD = 8, HF = 2;
  localparam int VS = 1, VB = 1, VD = 4, VF = 1;
  localparam int HT = HS + HB + HD + HF;
  localparam int VT = VS + VB + VD + VF;
  localparam int FRAME = HT * VT;
  localparam int FPP = 2, NPAT = 4;

  logic clk, rst_n, enable, next_req;
  logic data_req, de, hsync, vsync, frame_start, busy;
  logic [10:0] pixel_xpos, pixel_ypos, h_disp, v_disp;
  logic [1:0] pat_sel;
  logic [29:0] obs_vec;

  int total = 0, bad = 0;

  // Reference model: linear frame position (-1 = idle) plus scheduling state
  int m_pos, m_pat, m_fcnt;
  bit m_stop, m_pend;
  bit e1_dr, e1_fs, e1_hs, e1_vs, e_de, e_hs, e_vs;
  int e1_x, e1_y;

  lcd_pattern_scheduler #(
    .H_SYNC(HS), .H_BP(HB), .H_DISP(HD), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_DISP(VD), .V_FP(VF),
    .FRAMES_PER_PAT(FPP), .NUM_PAT(NPAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .next_req(next_req),
    .data_req(data_req), .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
    .h_disp(h_disp), .v_disp(v_disp), .de(de), .hsync(hsync), .vsync(vsync),
    .frame_start(frame_start), .pat_sel(pat_sel), .busy(busy)
  );

  assign obs_vec = {data_req, pixel_xpos, pixel_ypos, frame_start, de, hsync, vsync, pat_sel, busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = -1; m_pat = 0; m_fcnt = 0; m_stop = 0; m_pend = 0;
    e1_dr = 0; e1_fs = 0; e1_hs = 0; e1_vs = 0; e1_x = 0; e1_y = 0;
    e_de = 0; e_hs = 0; e_vs = 0;
  endtask

  task automatic model_step(input bit en, input bit nr);
    int p, x, y;
    bit last;
    p = m_pos;
    e_de = e1_dr; e_hs = e1_hs; e_vs = e1_vs;
    if (p >= 0) begin
      x = p % HT; y = p / HT;
      e1_dr = (x >= HS + HB) && (x < HS + HB + HD) && (y >= VS + VB) && (y < VS + VB + VD);
      e1_x  = e1_dr ? x - (HS + HB) : 0;
      e1_y  = e1_dr ? y - (VS + VB) : 0;
      e1_fs = (p == 0);
      e1_hs = (x < HS);
      e1_vs = (y < VS);
    end else begin
      e1_dr = 0; e1_x = 0; e1_y = 0; e1_fs = 0; e1_hs = 0; e1_vs = 0;
    end
    if (p < 0) begin
      if (en) begin m_pos = 0; m_stop = 0; end
    end else begin
      last = (p == FRAME - 1);
      if (last) begin
        if (m_fcnt == FPP - 1 || m_pend || nr) begin
          m_pat = (m_pat + 1) % NPAT; m_fcnt = 0; m_pend = 0;
        end else begin
          m_fcnt++;
        end
      end else if (nr) begin
        m_pend = 1;
      end
      m_pos = (p + 1) % FRAME;
      if (!m_stop) m_stop = !en;
      else if (en) m_stop = 0;
      else if (last) m_pos = -1;
    end
  endtask

  function automatic logic [29:0] exp_vec();
    return {e1_dr, 11'(e1_x), 11'(e1_y), e1_fs, e_de, e_hs, e_vs, 2'(m_pat), (m_pos >= 0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step(enable, next_req);
    #1;
    chk("cycle", 32'(obs_vec), 32'(exp_vec()));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; next_req = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset_outs", 32'(obs_vec), 32'd0);
  endtask

  task automatic wait_fs(input int limit);
    int n;
    n = 0;
    do begin tick(); n++; end while (!frame_start && n < limit);
    chk("fs_timeout", 32'(frame_start), 32'd1);
  endtask

  task automatic first_pixel(input string tag);
    int n;
    n = 0;
    do begin tick(); n++; end while (!data_req && n < 200);
    chk({tag, "_lat"}, n, 32'd39);
    chk({tag, "_x"}, 32'(pixel_xpos), 32'd0);
    chk({tag, "_y"}, 32'(pixel_ypos), 32'd0);
  endtask

  initial begin
    int n, cnt, run, drc, dec, hsc, vsc, xmax, ymax, de_bad;
    logic prev_dr;
    int exp_free[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    int exp_man[3]  = '{1, 1, 2};
    int exp_sim[3]  = '{1, 1, 2};

    rst_n = 1'b0; enable = 1'b0; next_req = 1'b0;
    #2;
    do_reset();
    chk("h_disp", 32'(h_disp), 32'd8);
    chk("v_disp", 32'(v_disp), 32'd4);

    // Enable: first pixel latency and one full-frame census
    enable = 1'b1;
    tick();
    first_pixel("first");
    wait_fs(200);
    drc = 0; dec = 0; hsc = 0; vsc = 0; xmax = 0; ymax = 0; run = 0; de_bad = 0;
    prev_dr = data_req;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      if (de !== prev_dr) de_bad++;
      prev_dr = data_req;
      if (data_req) begin
        drc++;
        if (int'(pixel_xpos) > xmax) xmax = int'(pixel_xpos);
        if (int'(pixel_ypos) > ymax) ymax = int'(pixel_ypos);
      end
      if (de) dec++;
      if (vsync) vsc++;
      if (hsync) begin hsc++; run++; end
      else begin
        if (run != 0) chk("hs_width", run, 32'd4);
        run = 0;
      end
    end
    chk("dr_per_frame", drc, 32'd32);
    chk("de_per_frame", dec, 32'd32);
    chk("xpos_max", xmax, 32'd7);
    chk("ypos_max", ymax, 32'd3);
    chk("hs_per_frame", hsc, 32'd28);
    chk("vs_per_frame", vsc, 32'd16);
    chk("de_delay", de_bad, 32'd0);

    // Free run pattern sequence
    do_reset();
    enable = 1'b1;
    tick();
    for (int f = 0; f < 9; f++) begin
      wait_fs(200);
      chk($sformatf("free_pat_f%0d", f), 32'(pat_sel), 32'(exp_free[f]));
    end

    // Manual advance: two requests in frame 0 coalesce
    do_reset();
    enable = 1'b1;
    tick();
    wait_fs(200);
    repeat (20) tick();
    next_req = 1'b1; tick(); next_req = 1'b0;
    repeat (30) tick();
    next_req = 1'b1; tick(); next_req = 1'b0;
    for (int f = 0; f < 3; f++) begin
      wait_fs(200);
      chk($sformatf("man_pat_f%0d", f + 1), 32'(pat_sel), 32'(exp_man[f]));
    end

    // Manual request in the auto-advance boundary cycle of frame 1
    do_reset();
    enable = 1'b1;
    tick();
    wait_fs(200);
    wait_fs(200);
    repeat (FRAME - 2) tick();
    next_req = 1'b1; tick(); next_req = 1'b0;
    for (int f = 0; f < 3; f++) begin
      wait_fs(200);
      chk($sformatf("sim_pat_f%0d", f + 2), 32'(pat_sel), 32'(exp_sim[f]));
    end

    // Stop mid-frame 1, drain, idle, then restart
    do_reset();
    enable = 1'b1;
    tick();
    wait_fs(200);
    wait_fs(200);
    cnt = 0; n = 0;
    do begin tick(); if (data_req) cnt++; n++; end
    while (!(data_req && pixel_ypos == 11'd1) && n < 200);
    enable = 1'b0;
    n = 0;
    do begin tick(); if (data_req) cnt++; n++; end while (busy && n < 300);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_dr_cnt", cnt, 32'd32);
    repeat (2) tick();
    chk("idle_flush", 32'(obs_vec[29:3]), 32'd0);
    chk("stop_pat", 32'(pat_sel), 32'd1);
    repeat (10) tick();
    chk("idle_pat_hold", 32'(pat_sel), 32'd1);
    enable = 1'b1;
    tick();
    first_pixel("restart");

    // Asynchronous reset in the active region of frame 2
    do_reset();
    enable = 1'b1;
    tick();
    wait_fs(200);
    wait_fs(200);
    wait_fs(200);
    chk("arst_pre_pat", 32'(pat_sel), 32'd1);
    n = 0;
    do begin tick(); n++; end while (!data_req && n < 200);
    chk("arst_active", 32'(data_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_outs", 32'(obs_vec), 32'd0);
    model_reset();
    repeat (2) tick();
    enable = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_pat", 32'(pat_sel), 32'd0);

    // Randomized enable/next_req traffic against the model
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 149) == 0) enable = ~enable;
      next_req = ($urandom_range(0, 29) == 0);
      tick();
    end
    next_req = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
